// File: rtl/lr35902_oam_dma_if.sv
// Bus bundle between the FF46 OAM DMA engine and its surroundings: CPU register
// access, the DMA read side of the external/video bus, and the OAM write port.
interface lr35902_oam_dma_if;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        read;
  logic        write;
  logic [7:0]  bus_din;
  logic [15:0] adr_dma;
  logic        rd_dma;
  logic        dma_active;
  logic        busy;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_data;
  logic        oam_wr;

  modport master (
    output din, read, write, bus_din,
    input  dout, adr_dma, rd_dma, dma_active, busy, oam_adr, oam_data, oam_wr
  );

  modport slave (
    input  din, read, write, bus_din,
    output dout, adr_dma, rd_dma, dma_active, busy, oam_adr, oam_data, oam_wr
  );
endinterface

// File: rtl/lr35902_oam_dma.sv
// OAM DMA engine behind FF46: after a short start delay, copies BYTES bytes from
// page {src,00} to OAM, one byte per CLKS_PER_BYTE clocks.
module lr35902_oam_dma #(
  parameter int BYTES         = 160,
  parameter int CLKS_PER_BYTE = 4,
  parameter int START_DELAY   = 4
) (
  input  logic              clk,
  input  logic              reset,
  lr35902_oam_dma_if.slave  bus
);

  localparam int SUB_W = $clog2(CLKS_PER_BYTE);
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         src_q, src_d;
  logic [7:0]         dout_q, dout_d;
  logic [7:0]         idx_q, idx_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               wr_prev_q;

  logic start;
  logic sub_last;
  logic idx_last;
  logic dly_last;
  logic unused_read;

  // Pages E0-FF are the echo of C0-DF; the DMA reads the underlying WRAM.
  function automatic logic [7:0] src_page(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

  assign start    = bus.write & ~wr_prev_q;
  assign sub_last = (sub_q == SUB_W'(CLKS_PER_BYTE - 1));
  assign idx_last = (idx_q == 8'(BYTES - 1));
  assign dly_last = (dly_q == DLY_W'(START_DELAY - 1));

  assign unused_read = bus.read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      dout_q    <= 8'h00;
      idx_q     <= 8'h00;
      sub_q     <= '0;
      dly_q     <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dout_q    <= dout_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      dly_q     <= dly_d;
      wr_prev_q <= bus.write;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    dly_d   = dly_q;

    // A start edge wins over everything, including a restart mid-transfer.
    if (start) begin
      dout_d  = bus.din;
      src_d   = src_page(bus.din);
      idx_d   = 8'h00;
      sub_d   = '0;
      dly_d   = '0;
      state_d = DELAY;
    end else begin
      case (state_q)
        DELAY: begin
          dly_d = dly_q + 1'b1;
          if (dly_last) begin
            idx_d   = 8'h00;
            sub_d   = '0;
            state_d = XFER;
          end
        end
        XFER: begin
          sub_d = sub_q + 1'b1;
          if (sub_last) begin
            if (idx_last) begin
              state_d = IDLE;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign bus.busy       = (state_q != IDLE);
  assign bus.dma_active = (state_q == XFER);
  assign bus.rd_dma     = (state_q == XFER);
  assign bus.oam_wr     = (state_q == XFER) & sub_last & ~start;
  assign bus.adr_dma    = {src_q, idx_q};
  assign bus.oam_adr    = idx_q;
  assign bus.oam_data   = bus.bus_din;
  assign bus.dout       = dout_q;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Scoreboard bench for the FF46 OAM DMA engine with a combinational bus model.
module tb_lr35902_oam_dma;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] adr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic reset;
  lr35902_oam_dma_if bus();

  exp_t sb[$];
  int   tests;
  int   fails;
  int   busy_cnt;
  int   act_cnt;
  int   wr_cnt;

  lr35902_oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
  endfunction

  assign bus.bus_din = mem(bus.adr_dma);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_xfer(input logic [7:0] v);
    logic [7:0] src;
    src = (v >= 8'hE0) ? v - 8'h20 : v;
    for (int i = 0; i < 160; i++) begin
      exp_t e;
      e.idx  = 8'(i);
      e.adr  = {src, 8'(i)};
      e.data = mem({src, 8'(i)});
      sb.push_back(e);
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the edge; OAM writes are scored here.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.busy) busy_cnt++;
    if (bus.dma_active) act_cnt++;
    if (bus.oam_wr) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("oam_adr", 32'(bus.oam_adr), 32'(e.idx));
        check("adr_dma", 32'(bus.adr_dma), 32'(e.adr));
        check("oam_data", 32'(bus.oam_data), 32'(e.data));
      end
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (bus.busy && n < max) begin
      tick();
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_wr(input int target, input int max);
    int n;
    n = 0;
    while (wr_cnt < target && n < max) begin
      tick();
      n++;
    end
    if (wr_cnt < target) check("wr_timeout", 32'(wr_cnt), 32'(target));
  endtask

  initial begin
    int b0, a0, w0;
    tests = 0; fails = 0; busy_cnt = 0; act_cnt = 0; wr_cnt = 0;
    bus.din = 8'h00; bus.read = 1'b0; bus.write = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dma_active", 32'(bus.dma_active), 32'd0);
    check("rst_rd_dma", 32'(bus.rd_dma), 32'd0);
    check("rst_oam_wr", 32'(bus.oam_wr), 32'd0);
    check("rst_adr_dma", 32'(bus.adr_dma), 32'h0000);
    check("rst_oam_adr", 32'(bus.oam_adr), 32'h00);
    check("rst_dout", 32'(bus.dout), 32'h00);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Basic transfer from C1xx
    b0 = busy_cnt; a0 = act_cnt; w0 = wr_cnt;
    push_xfer(8'hC1);
    check("t1_busy_before", 32'(bus.busy), 32'd0);
    bus.din = 8'hC1; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    check("t1_busy_rise", 32'(bus.busy), 32'd1);
    check("t1_dma_delay0", 32'(bus.dma_active), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t1_dma_delay", 32'(bus.dma_active), 32'd0);
    end
    tick();
    check("t1_dma_rise", 32'(bus.dma_active), 32'd1);
    check("t1_rd_dma", 32'(bus.rd_dma), 32'd1);
    check("t1_first_adr", 32'(bus.adr_dma), 32'hC100);
    wait_idle(800);
    check("t1_busy_clks", 32'(busy_cnt - b0), 32'd644);
    check("t1_active_clks", 32'(act_cnt - a0), 32'd640);
    check("t1_wr_pulses", 32'(wr_cnt - w0), 32'd160);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_dout", 32'(bus.dout), 32'hC1);
    check("t1_adr_hold", 32'(bus.adr_dma), 32'hC19F);
    check("t1_oam_adr_hold", 32'(bus.oam_adr), 32'h9F);
    check("t1_rd_idle", 32'(bus.rd_dma), 32'd0);

    // Echo-RAM page aliases down by 0x20
    w0 = wr_cnt;
    push_xfer(8'hFE);
    bus.din = 8'hFE; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    repeat (4) tick();
    check("t2_first_adr", 32'(bus.adr_dma), 32'hDE00);
    wait_idle(800);
    check("t2_wr_pulses", 32'(wr_cnt - w0), 32'd160);
    check("t2_last_adr", 32'(bus.adr_dma), 32'hDE9F);
    check("t2_dout", 32'(bus.dout), 32'hFE);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Restart after 50 bytes
    w0 = wr_cnt;
    push_xfer(8'h80);
    bus.din = 8'h80; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    wait_wr(w0 + 50, 400);
    tick();
    sb.delete();
    push_xfer(8'h90);
    bus.din = 8'h90; bus.write = 1'b1;
    check("t3_no_wr_restart", 32'(bus.oam_wr), 32'd0);
    b0 = busy_cnt;
    tick();
    bus.write = 1'b0;
    check("t3_wr_before", 32'(wr_cnt - w0), 32'd50);
    check("t3_dout", 32'(bus.dout), 32'h90);
    for (int i = 0; i < 4; i++) begin
      check("t3_dma_low", 32'(bus.dma_active), 32'd0);
      check("t3_busy_hold", 32'(bus.busy), 32'd1);
      tick();
    end
    check("t3_dma_back", 32'(bus.dma_active), 32'd1);
    check("t3_restart_adr", 32'(bus.adr_dma), 32'h9000);
    check("t3_restart_oam", 32'(bus.oam_adr), 32'h00);
    wait_idle(800);
    check("t3_busy_clks", 32'(busy_cnt - b0), 32'd644);
    check("t3_wr_total", 32'(wr_cnt - w0), 32'd210);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Long write strobe starts one transfer only
    w0 = wr_cnt; b0 = busy_cnt;
    push_xfer(8'hC0);
    bus.din = 8'hC0; bus.write = 1'b1;
    repeat (10) tick();
    bus.write = 1'b0;
    wait_idle(800);
    repeat (20) tick();
    check("t4_wr_pulses", 32'(wr_cnt - w0), 32'd160);
    check("t4_busy_clks", 32'(busy_cnt - b0), 32'd644);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Readback during XFER, then async reset at byte 80
    w0 = wr_cnt;
    push_xfer(8'hA5);
    bus.din = 8'hA5; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.din = 8'h33;
    bus.read = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      check("t5_dout_xfer", 32'(bus.dout), 32'hA5);
      tick();
    end
    bus.read = 1'b0;
    wait_wr(w0 + 80, 400);
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("t6_dma_async", 32'(bus.dma_active), 32'd0);
    check("t6_rd_async", 32'(bus.rd_dma), 32'd0);
    check("t6_wr_async", 32'(bus.oam_wr), 32'd0);
    check("t6_busy_async", 32'(bus.busy), 32'd0);
    check("t6_dout_async", 32'(bus.dout), 32'h00);
    check("t6_wr_count", 32'(wr_cnt - w0), 32'd80);
    repeat (2) tick();
    reset = 1'b0;
    sb.delete();
    w0 = wr_cnt; b0 = busy_cnt;
    repeat (50) tick();
    check("t6_no_wr_after", 32'(wr_cnt - w0), 32'd0);
    check("t6_no_busy_after", 32'(busy_cnt - b0), 32'd0);
    check("t6_dout_after", 32'(bus.dout), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
